// File: rtl/lsu_split_access.sv
// Load/store unit between the MEM stage and a valid/ack data bus.
// Accesses that cross a word boundary are split into two beats, and each beat has its own timeout.
module lsu_split_access #(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_error,
    output logic              busy,
    output logic [XLEN-1:0]   bus_addr,
    output logic              bus_read_enable,
    output logic              bus_write_enable,
    output logic [XLEN-1:0]   bus_write_data,
    output logic [XLEN/8-1:0] bus_write_mask,
    input  logic [XLEN-1:0]   bus_read_data,
    input  logic              bus_ack
);

    localparam int BYTES = XLEN / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state_q;
    logic [OFS-1:0]    off_q;
    logic [2:0]        funct3_q;
    logic              write_q;
    logic              cross_q;
    logic [XLEN-1:0]   hiData_q;
    logic [BYTES-1:0]  hiMask_q;
    logic [XLEN-1:0]   rawLow_q;
    logic [CNT_W-1:0]  beatCnt_q;
    logic              respValid_q;
    logic              respError_q;
    logic [XLEN-1:0]   respRdata_q;
    logic [4:0]        respRd_q;
    logic [XLEN-1:0]   busAddr_q;
    logic              busRdEn_q;
    logic              busWrEn_q;
    logic [XLEN-1:0]   busWdata_q;
    logic [BYTES-1:0]  busMask_q;

    logic [OFS-1:0]      reqOff;
    logic                reqLegal;
    logic                reqCross;
    logic [2*XLEN-1:0]   reqLane;
    logic [2*BYTES-1:0]  reqMask;
    logic [XLEN-1:0]     lowPart;
    logic [XLEN-1:0]     highPart;
    logic [XLEN-1:0]     loadResult_d;
    logic                beatActive;
    logic                timeoutHit;

    function automatic logic isLegal(input logic write, input logic [2:0] f3);
        if (write) begin
            return (f3[2] == 1'b0) && ((f3[1:0] != 2'b11) || (XLEN == 64));
        end
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
            3'b011, 3'b110:                         return XLEN == 64;
            default:                                return 1'b0;
        endcase
    endfunction

    // funct3[2] set means zero-extend; full-width accesses pass straight through.
    function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0] raw, input logic [2:0] f3);
        logic [XLEN-1:0] keep;
        logic [XLEN-1:0] shifted;
        int bits;
        bits = 8 << f3[1:0];
        if (bits >= XLEN) begin
            return raw;
        end
        keep    = ~({XLEN{1'b1}} << bits);
        shifted = raw >> (bits - 1);
        if (!f3[2] && shifted[0]) begin
            return raw | ~keep;
        end
        return raw & keep;
    endfunction

    // Store data and byte mask are laid out across two words; the high word feeds the second beat.
    always_comb begin
        reqOff   = req_addr[OFS-1:0];
        reqLegal = isLegal(req_write, req_funct3);
        reqCross = (int'(reqOff) + (1 << req_funct3[1:0])) > BYTES;
        reqLane  = {{XLEN{1'b0}}, req_wdata} << {reqOff, 3'b000};
        reqMask  = ~({2*BYTES{1'b1}} << (1 << req_funct3[1:0]));
        reqMask  = reqMask << reqOff;
    end

    always_comb begin
        lowPart      = bus_read_data >> {off_q, 3'b000};
        highPart     = bus_read_data << (XLEN - 8 * int'(off_q));
        loadResult_d = extendLoad((state_q == BEAT1) ? (rawLow_q | highPart) : lowPart, funct3_q);
    end

    assign beatActive = busRdEn_q | busWrEn_q;
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (beatCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // An inactive enable in a beat state is the mandatory idle cycle before the second beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            off_q       <= '0;
            funct3_q    <= '0;
            write_q     <= 1'b0;
            cross_q     <= 1'b0;
            hiData_q    <= '0;
            hiMask_q    <= '0;
            rawLow_q    <= '0;
            beatCnt_q   <= '0;
            respValid_q <= 1'b0;
            respError_q <= 1'b0;
            respRdata_q <= '0;
            respRd_q    <= '0;
            busAddr_q   <= '0;
            busRdEn_q   <= 1'b0;
            busWrEn_q   <= 1'b0;
            busWdata_q  <= '0;
            busMask_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        off_q    <= reqOff;
                        funct3_q <= req_funct3;
                        write_q  <= req_write;
                        cross_q  <= reqCross;
                        hiData_q <= reqLane[2*XLEN-1:XLEN];
                        hiMask_q <= reqMask[2*BYTES-1:BYTES];
                        respRd_q <= req_rd;
                        if (!reqLegal || (reqCross && !ALLOW_MISALIGNED)) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respError_q <= 1'b1;
                            respRdata_q <= '0;
                        end else begin
                            state_q    <= BEAT0;
                            beatCnt_q  <= '0;
                            busAddr_q  <= {req_addr[XLEN-1:OFS], {OFS{1'b0}}};
                            busRdEn_q  <= !req_write;
                            busWrEn_q  <= req_write;
                            busWdata_q <= reqLane[XLEN-1:0];
                            busMask_q  <= reqMask[BYTES-1:0];
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (!beatActive) begin
                        busRdEn_q <= !write_q;
                        busWrEn_q <= write_q;
                        beatCnt_q <= '0;
                    end else if (bus_ack) begin
                        busRdEn_q <= 1'b0;
                        busWrEn_q <= 1'b0;
                        if (state_q == BEAT0 && cross_q) begin
                            state_q    <= BEAT1;
                            rawLow_q   <= lowPart;
                            busAddr_q  <= busAddr_q + XLEN'(BYTES);
                            busWdata_q <= hiData_q;
                            busMask_q  <= hiMask_q;
                        end else begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respError_q <= 1'b0;
                            respRdata_q <= write_q ? '0 : loadResult_d;
                        end
                    end else if (timeoutHit) begin
                        busRdEn_q   <= 1'b0;
                        busWrEn_q   <= 1'b0;
                        state_q     <= RESP;
                        respValid_q <= 1'b1;
                        respError_q <= 1'b1;
                        respRdata_q <= '0;
                    end else begin
                        beatCnt_q <= beatCnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    respValid_q <= 1'b0;
                    respError_q <= 1'b0;
                    respRdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign resp_valid       = respValid_q;
    assign resp_error       = respError_q;
    assign resp_rdata       = respRdata_q;
    assign resp_rd          = respRd_q;
    assign bus_addr         = busAddr_q;
    assign bus_read_enable  = busRdEn_q;
    assign bus_write_enable = busWrEn_q;
    assign bus_write_data   = busWdata_q;
    assign bus_write_mask   = busMask_q;

endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access at XLEN=32: vector table plus hand-written
// timeout, ALLOW_MISALIGNED=0 and mid-access reset sequences.
module tb_lsu_split_access;

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
        int          beats;
        logic [31:0] addr0;
        logic [31:0] data0;
        logic [3:0]  mask0;
        logic [31:0] addr1;
        logic [31:0] data1;
        logic [3:0]  mask1;
        logic [31:0] expRdata;
        logic        expError;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValidA, reqValidB;
    logic        reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr, reqWdata;
    logic [4:0]  reqRd;
    logic [31:0] busRdata;
    logic        busAck;

    logic        reqReadyA, respValidA, respErrorA, busyA, busRdEnA, busWrEnA;
    logic [31:0] respRdataA, busAddrA, busWdataA;
    logic [4:0]  respRdA;
    logic [3:0]  busMaskA;
    logic        reqReadyB, respValidB, respErrorB, busyB, busRdEnB, busWrEnB;
    logic [31:0] respRdataB, busAddrB, busWdataB;
    logic [4:0]  respRdB;
    logic [3:0]  busMaskB;

    int checks = 0;
    int failures = 0;
    vec_t vecs[13];

    always #5 clk = ~clk;

    lsu_split_access #(.XLEN(32), .ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(8)) dutA (
        .clk(clk), .rst(rst),
        .req_valid(reqValidA), .req_ready(reqReadyA), .req_write(reqWrite),
        .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata), .req_rd(reqRd),
        .resp_valid(respValidA), .resp_rdata(respRdataA), .resp_rd(respRdA),
        .resp_error(respErrorA), .busy(busyA),
        .bus_addr(busAddrA), .bus_read_enable(busRdEnA), .bus_write_enable(busWrEnA),
        .bus_write_data(busWdataA), .bus_write_mask(busMaskA),
        .bus_read_data(busRdata), .bus_ack(busAck)
    );

    lsu_split_access #(.XLEN(32), .ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(8)) dutB (
        .clk(clk), .rst(rst),
        .req_valid(reqValidB), .req_ready(reqReadyB), .req_write(reqWrite),
        .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata), .req_rd(reqRd),
        .resp_valid(respValidB), .resp_rdata(respRdataB), .resp_rd(respRdB),
        .resp_error(respErrorB), .busy(busyB),
        .bus_addr(busAddrB), .bus_read_enable(busRdEnB), .bus_write_enable(busWrEnB),
        .bus_write_data(busWdataB), .bus_write_mask(busMaskB),
        .bus_read_data(busRdata), .bus_ack(busAck)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setRequest(input logic write, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd);
        reqWrite  = write;
        reqFunct3 = f3;
        reqAddr   = addr;
        reqWdata  = wdata;
        reqRd     = rd;
    endtask

    // Runs one request on dutA, acking each beat in its third active cycle.
    task automatic applyStimulus(input vec_t v, input int idx);
        int waited;
        setRequest(v.write, v.f3, v.addr, v.wdata, v.rd);
        reqValidA = 1'b1;
        tick();
        reqValidA = 1'b0;
        for (int b = 0; b < v.beats; b++) begin
            waited = 0;
            while (!(busRdEnA || busWrEnA) && waited < 5) begin
                tick();
                waited++;
            end
            if (b == 1) checkOutput($sformatf("v%0d gap cycles", idx), waited, 1);
            checkOutput($sformatf("v%0d.b%0d wr_en", idx, b), {31'b0, busWrEnA}, {31'b0, v.write});
            checkOutput($sformatf("v%0d.b%0d rd_en", idx, b), {31'b0, busRdEnA}, {31'b0, !v.write});
            checkOutput($sformatf("v%0d.b%0d busy", idx, b), {31'b0, busyA}, 32'd1);
            checkOutput($sformatf("v%0d.b%0d addr", idx, b), busAddrA, (b == 0) ? v.addr0 : v.addr1);
            if (v.write) begin
                checkOutput($sformatf("v%0d.b%0d wdata", idx, b), busWdataA, (b == 0) ? v.data0 : v.data1);
                checkOutput($sformatf("v%0d.b%0d mask", idx, b), {28'b0, busMaskA},
                            {28'b0, (b == 0) ? v.mask0 : v.mask1});
            end
            tick();
            tick();
            busAck   = 1'b1;
            busRdata = (b == 0) ? v.rdata0 : v.rdata1;
            tick();
            busAck   = 1'b0;
            busRdata = 32'h0;
            if (b < v.beats - 1) begin
                checkOutput($sformatf("v%0d early resp", idx), {31'b0, respValidA}, 32'd0);
            end
        end
        checkOutput($sformatf("v%0d resp_valid", idx), {31'b0, respValidA}, 32'd1);
        checkOutput($sformatf("v%0d resp_error", idx), {31'b0, respErrorA}, {31'b0, v.expError});
        checkOutput($sformatf("v%0d resp_rdata", idx), respRdataA, v.expRdata);
        checkOutput($sformatf("v%0d resp_rd", idx), {27'b0, respRdA}, {27'b0, v.rd});
        checkOutput($sformatf("v%0d enables off", idx), {30'b0, busRdEnA, busWrEnA}, 32'd0);
        tick();
        checkOutput($sformatf("v%0d resp pulse", idx), {31'b0, respValidA}, 32'd0);
        checkOutput($sformatf("v%0d ready", idx), {31'b0, reqReadyA}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 32'hDEADBEEF, 32'h0, 1,
                     32'h100, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 32'h80123456, 32'h0, 1,
                     32'h100, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 5'd17, 32'h80123456, 32'h0, 1,
                     32'h100, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h00000080, 1'b0};
        vecs[3]  = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd2, 32'h0, 32'h0, 1,
                     32'h100, 32'hABCD0000, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 3'b010, 32'h0FE, 32'h0, 5'd9, 32'hBBAA0000, 32'h0000DDCC, 2,
                     32'h0FC, 32'h0, 4'h0, 32'h100, 32'h0, 4'h0, 32'hDDCCBBAA, 1'b0};
        vecs[5]  = '{1'b1, 3'b010, 32'h0FE, 32'hDDCCBBAA, 5'd10, 32'h0, 32'h0, 2,
                     32'h0FC, 32'hBBAA0000, 4'hC, 32'h100, 32'h0000DDCC, 4'h3, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 3'b001, 32'h0FF, 32'h0, 5'd3, 32'hAB000000, 32'h112233CD, 2,
                     32'h0FC, 32'h0, 4'h0, 32'h100, 32'h0, 4'h0, 32'hFFFFCDAB, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 32'h102, 32'h0, 5'd12, 32'h87654321, 32'h0, 1,
                     32'h100, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h00008765, 1'b0};
        vecs[8]  = '{1'b1, 3'b000, 32'h101, 32'h123456EE, 5'd13, 32'h0, 32'h0, 1,
                     32'h100, 32'h3456EE00, 4'h2, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd30, 32'h22110000, 32'h00004433, 2,
                     32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h44332211, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 32'h100, 32'h0, 5'd7, 32'h0, 32'h0, 0,
                     32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 3'b100, 32'h100, 32'h55555555, 5'd6, 32'h0, 32'h0, 0,
                     32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 3'b010, 32'h201, 32'hA1B2C3D4, 5'd14, 32'h0, 32'h0, 2,
                     32'h200, 32'hB2C3D400, 4'hE, 32'h204, 32'h000000A1, 4'h1, 32'h0, 1'b0};

        rst = 1'b0;
        reqValidA = 1'b0;
        reqValidB = 1'b0;
        busAck = 1'b0;
        busRdata = 32'h0;
        setRequest(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        #12;
        checkOutput("reset req_ready", {31'b0, reqReadyA}, 32'd1);
        checkOutput("reset busy", {31'b0, busyA}, 32'd0);
        checkOutput("reset enables", {30'b0, busRdEnA, busWrEnA}, 32'd0);
        checkOutput("reset resp_valid", {31'b0, respValidA}, 32'd0);
        checkOutput("reset bus_addr", busAddrA, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] timeout with no ack");
        setRequest(1'b0, 3'b010, 32'h200, 32'h0, 5'd8);
        reqValidA = 1'b1;
        tick();
        reqValidA = 1'b0;
        n = 0;
        while (busRdEnA && n < 20) begin
            n++;
            tick();
        end
        checkOutput("timeout beat cycles", n, 8);
        checkOutput("timeout resp_valid", {31'b0, respValidA}, 32'd1);
        checkOutput("timeout resp_error", {31'b0, respErrorA}, 32'd1);
        checkOutput("timeout resp_rdata", respRdataA, 32'h0);
        tick();

        $display("[TB] ack in the cycle the timeout expires");
        setRequest(1'b0, 3'b010, 32'h300, 32'h0, 5'd4);
        reqValidA = 1'b1;
        tick();
        reqValidA = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        checkOutput("late ack rd_en", {31'b0, busRdEnA}, 32'd1);
        busAck = 1'b1;
        busRdata = 32'h55AA55AA;
        tick();
        busAck = 1'b0;
        checkOutput("late ack resp_valid", {31'b0, respValidA}, 32'd1);
        checkOutput("late ack resp_error", {31'b0, respErrorA}, 32'd0);
        checkOutput("late ack resp_rdata", respRdataA, 32'h55AA55AA);
        tick();

        $display("[TB] ALLOW_MISALIGNED=0 instance");
        setRequest(1'b0, 3'b010, 32'h0FE, 32'h0, 5'd21);
        reqValidB = 1'b1;
        tick();
        reqValidB = 1'b0;
        checkOutput("nomis resp_valid", {31'b0, respValidB}, 32'd1);
        checkOutput("nomis resp_error", {31'b0, respErrorB}, 32'd1);
        checkOutput("nomis resp_rd", {27'b0, respRdB}, 32'd21);
        checkOutput("nomis enables", {30'b0, busRdEnB, busWrEnB}, 32'd0);
        tick();
        checkOutput("nomis resp pulse", {31'b0, respValidB}, 32'd0);
        setRequest(1'b0, 3'b011, 32'h100, 32'h0, 5'd22);
        reqValidB = 1'b1;
        tick();
        reqValidB = 1'b0;
        checkOutput("nomis ld error", {31'b0, respErrorB}, 32'd1);
        checkOutput("nomis ld enables", {30'b0, busRdEnB, busWrEnB}, 32'd0);
        tick();

        $display("[TB] reset during second beat");
        setRequest(1'b1, 3'b010, 32'h0FE, 32'hDDCCBBAA, 5'd11);
        reqValidA = 1'b1;
        tick();
        reqValidA = 1'b0;
        busAck = 1'b1;
        tick();
        busAck = 1'b0;
        tick();
        checkOutput("rst-mid wr_en before", {31'b0, busWrEnA}, 32'd1);
        checkOutput("rst-mid addr before", busAddrA, 32'h100);
        rst = 1'b0;
        #1;
        checkOutput("rst-mid enables", {30'b0, busRdEnA, busWrEnA}, 32'd0);
        checkOutput("rst-mid ready", {31'b0, reqReadyA}, 32'd1);
        checkOutput("rst-mid busy", {31'b0, busyA}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checkOutput("post-rst ready", {31'b0, reqReadyA}, 32'd1);
        checkOutput("post-rst resp_valid", {31'b0, respValidA}, 32'd0);
        applyStimulus(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
